// File: rtl/types_pkg.sv
// Shared types for the operator-entry front end.
//   word_t        : switch-bank / operand word
//   opr_mode_t    : operation selector; declaration order is the UP/DOWN step order
//   commit_t      : committed {mode, operand} pair handed to the datapath
//   entry_state_t : operator-entry FSM states
//   mode_next/prev: wrap-around stepping through opr_mode_t
package types_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned MODE_W = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [MODE_W-1:0] {
    ADD,
    SUB,
    MUL,
    SHL,
    SHR,
    CMP
  } opr_mode_t;

  localparam opr_mode_t MODE_FIRST = ADD;
  localparam opr_mode_t MODE_LAST  = CMP;

  typedef struct packed {
    opr_mode_t mode;
    word_t     operand;
  } commit_t;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT
  } entry_state_t;

  // Step forward in declaration order, wrapping from the last member to ADD.
  function automatic opr_mode_t mode_next(input opr_mode_t m);
    opr_mode_t r;
    if (m == MODE_LAST) r = MODE_FIRST;
    else                r = opr_mode_t'(MODE_W'(m) + MODE_W'(1));
    return r;
  endfunction

  // Step backward in declaration order, wrapping from ADD to the last member.
  function automatic opr_mode_t mode_prev(input opr_mode_t m);
    opr_mode_t r;
    if (m == MODE_FIRST) r = MODE_LAST;
    else                 r = opr_mode_t'(MODE_W'(m) - MODE_W'(1));
    return r;
  endfunction

endpackage

// File: rtl/op_entry_ctrl_if.sv
// Operator-entry bus: raw panel inputs in, committed selection out.
//   BTN_ENTER/BTN_UP/BTN_DOWN : raw push buttons
//   SW_RAW                    : raw switch bank
//   SELECTOR/SW               : committed mode and operand
//   PEND_MODE                 : mode currently being edited
//   UPDATE                    : one-cycle strobe when SELECTOR/SW change
// master = panel side (drives buttons/switches), slave = controller side.
interface op_entry_ctrl_if;
  import types_pkg::*;

  logic      BTN_ENTER;
  logic      BTN_UP;
  logic      BTN_DOWN;
  word_t     SW_RAW;
  opr_mode_t SELECTOR;
  word_t     SW;
  opr_mode_t PEND_MODE;
  logic      UPDATE;

  modport master (
    output BTN_ENTER, BTN_UP, BTN_DOWN, SW_RAW,
    input  SELECTOR, SW, PEND_MODE, UPDATE
  );

  modport slave (
    input  BTN_ENTER, BTN_UP, BTN_DOWN, SW_RAW,
    output SELECTOR, SW, PEND_MODE, UPDATE
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, then a level debouncer that
// accepts a new level only after DEBOUNCE_CYCLES consecutive cycles of it.
// Each accepted 0->1 transition emits one registered PULSE, 2+DEBOUNCE_CYCLES
// cycles after the raw edge.
//   clk, rst : clock, asynchronous active-high reset
//   BTN_RAW  : raw (bouncy, asynchronous) button level
//   PULSE    : one-cycle pulse per accepted press
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic BTN_RAW,
  output logic PULSE
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [1:0]       warm_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Debounce: count consecutive disagreeing samples; any agreement restarts.
  // The counter stops at CNT_LAST (acceptance), so it can never wrap.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (warm_q[1]) begin
      if (sync_q[1] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        cnt_d   = '0;
        pulse_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Accepted level resets to "pressed" so a button held through reset must
  // be released and pressed again before it can pulse. warm_q holds off
  // comparisons until the synchronizer carries real samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      warm_q  <= 2'b00;
      level_q <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], BTN_RAW};
      warm_q  <= {warm_q[0], 1'b1};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign PULSE = pulse_q;

endmodule

// File: rtl/op_entry_ctrl.sv
// Operator-entry controller: three debounced buttons edit a pending mode
// (UP/DOWN) and commit it together with the synchronized switch bank (ENTER).
// An edit left untouched for TIMEOUT_CYCLES is discarded.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : op_entry_ctrl_if.slave
//              in : BTN_ENTER, BTN_UP, BTN_DOWN, SW_RAW
//              out: SELECTOR, SW (committed), PEND_MODE (editing), UPDATE (strobe)
module op_entry_ctrl
  import types_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic            clk,
  input  logic            rst,
  op_entry_ctrl_if.slave  bus
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic enter_p;
  logic up_p;
  logic down_p;

  word_t            sw_s1_q, sw_s2_q;
  entry_state_t     state_q, state_d;
  opr_mode_t        pend_q, pend_d;
  commit_t          commit_q, commit_d;
  logic             upd_q, upd_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic      step_req;
  opr_mode_t step_mode;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_enter (
    .clk     (clk),
    .rst     (rst),
    .BTN_RAW (bus.BTN_ENTER),
    .PULSE   (enter_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_up (
    .clk     (clk),
    .rst     (rst),
    .BTN_RAW (bus.BTN_UP),
    .PULSE   (up_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_down (
    .clk     (clk),
    .rst     (rst),
    .BTN_RAW (bus.BTN_DOWN),
    .PULSE   (down_p)
  );

  // Simultaneous UP and DOWN cancel out: only a lone direction steps.
  assign step_req  = up_p ^ down_p;
  assign step_mode = up_p ? mode_next(pend_q) : mode_prev(pend_q);

  // Next-state / output logic. Commit values are loaded on the transition
  // into COMMIT so UPDATE and the new SELECTOR/SW appear in the same cycle,
  // one cycle after the ENTER pulse. ENTER has priority over any step.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    commit_d = commit_q;
    upd_d    = 1'b0;
    tmo_d    = tmo_q;

    case (state_q)
      IDLE: begin
        if (enter_p) begin
          state_d          = COMMIT;
          commit_d.mode    = pend_q;
          commit_d.operand = sw_s2_q;
          upd_d            = 1'b1;
          tmo_d            = '0;
        end else if (step_req) begin
          state_d = EDIT;
          pend_d  = step_mode;
          tmo_d   = '0;
        end
      end

      EDIT: begin
        if (enter_p) begin
          state_d          = COMMIT;
          commit_d.mode    = pend_q;
          commit_d.operand = sw_s2_q;
          upd_d            = 1'b1;
          tmo_d            = '0;
        end else if (step_req) begin
          pend_d = step_mode;
          tmo_d  = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Edit abandoned: fall back to what is actually committed.
          state_d = IDLE;
          pend_d  = commit_q.mode;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      // Single-cycle strobe state; pulses arriving here are dropped.
      COMMIT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, switch synchronizer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      state_q  <= IDLE;
      pend_q   <= ADD;
      commit_q <= '{mode: ADD, operand: '0};
      upd_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      sw_s1_q  <= bus.SW_RAW;
      sw_s2_q  <= sw_s1_q;
      state_q  <= state_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
      upd_q    <= upd_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.SELECTOR  = commit_q.mode;
  assign bus.SW        = commit_q.operand;
  assign bus.PEND_MODE = pend_q;
  assign bus.UPDATE    = upd_q;

endmodule

// File: tb/tb_op_entry_ctrl.sv
// Self-checking bench for op_entry_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_op_entry_ctrl;
  import types_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 20;

  logic clk = 1'b0;
  logic rst;

  op_entry_ctrl_if bus ();

  op_entry_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic      enter;
    logic      up;
    logic      dn;
    word_t     sw_raw;
    opr_mode_t exp_sel;
    word_t     exp_sw;
    opr_mode_t exp_pend;
    int        exp_upd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic e, input logic u, input logic d);
    bus.BTN_ENTER = e;
    bus.BTN_UP    = u;
    bus.BTN_DOWN  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    int upd_cnt;
    int upd_at;

    // press, hold 8 cycles, release; state carried over between rows
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'hFFFF, ADD, 16'h00A5, CMP, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, ADD, 16'h00A5, ADD, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, ADD, 16'h00A5, SUB, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, ADD, 16'h00A5, MUL, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0042, MUL, 16'h0042, MUL, 1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h1234, MUL, 16'h1234, MUL, 1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h1234, MUL, 16'h1234, MUL, 0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'hBEEF, MUL, 16'hBEEF, MUL, 1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'hBEEF, MUL, 16'hBEEF, SUB, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'hBEEF, MUL, 16'hBEEF, ADD, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'hBEEF, MUL, 16'hBEEF, CMP, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h00FF, CMP, 16'h00FF, CMP, 1};

    rst = 1'b1;
    set_btn(1'b0, 1'b0, 1'b0);
    bus.SW_RAW = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_sel",   32'(bus.SELECTOR),  32'(ADD));
    chk("rst_sw",    32'(bus.SW),        32'h0);
    chk("rst_pend",  32'(bus.PEND_MODE), 32'(ADD));
    chk("rst_upd",   32'(bus.UPDATE),    32'h0);
    chk("rst_state", 32'(dut.state_q),   32'(IDLE));
    rst = 1'b0;

    // 100 quiet cycles after reset release
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("quiet", 32'({bus.SELECTOR, bus.SW, bus.PEND_MODE, bus.UPDATE}), 32'h0);
    end

    // ENTER held 10 cycles: UPDATE exactly once, 7 cycles after the raw edge
    bus.SW_RAW = 16'h00A5;
    repeat (4) @(negedge clk);
    upd_cnt = 0;
    upd_at  = -1;
    bus.BTN_ENTER = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.UPDATE) begin
        upd_cnt++;
        upd_at = c;
      end
      if (c == 10) bus.BTN_ENTER = 1'b0;
    end
    chk("enter_upd_count", 32'(upd_cnt), 32'd1);
    chk("enter_upd_cycle", 32'(upd_at),  32'd7);
    chk("enter_sw",        32'(bus.SW),       32'h00A5);
    chk("enter_sel",       32'(bus.SELECTOR), 32'(ADD));
    repeat (4) @(negedge clk);

    // table of single presses
    for (int i = 0; i < 12; i++) begin
      bus.SW_RAW = vecs[i].sw_raw;
      set_btn(vecs[i].enter, vecs[i].up, vecs[i].dn);
      upd_cnt = 0;
      for (int c = 1; c <= 16; c++) begin
        @(negedge clk);
        if (bus.UPDATE) upd_cnt++;
        if (c == 8) set_btn(1'b0, 1'b0, 1'b0);
      end
      chk($sformatf("v%0d_sel", i),  32'(bus.SELECTOR),  32'(vecs[i].exp_sel));
      chk($sformatf("v%0d_sw", i),   32'(bus.SW),        32'(vecs[i].exp_sw));
      chk($sformatf("v%0d_pend", i), 32'(bus.PEND_MODE), 32'(vecs[i].exp_pend));
      chk($sformatf("v%0d_upd", i),  32'(upd_cnt),       32'(vecs[i].exp_upd));
    end

    // edit timeout: UP from CMP wraps to ADD, reverts after 20 idle EDIT cycles
    upd_cnt = 0;
    set_btn(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.UPDATE) upd_cnt++;
      if (c == 8) set_btn(1'b0, 1'b0, 1'b0);
      if (c == 10) begin
        chk("tmo_pend_edit",  32'(bus.PEND_MODE), 32'(ADD));
        chk("tmo_state_edit", 32'(dut.state_q),   32'(EDIT));
      end
      if (c == 26) chk("tmo_pend_last", 32'(bus.PEND_MODE), 32'(ADD));
      if (c == 27) begin
        chk("tmo_pend_revert", 32'(bus.PEND_MODE), 32'(CMP));
        chk("tmo_state_idle",  32'(dut.state_q),   32'(IDLE));
      end
    end
    chk("tmo_no_update", 32'(upd_cnt),      32'd0);
    chk("tmo_sel",       32'(bus.SELECTOR), 32'(CMP));

    // bouncing ENTER (2 high / 2 low for 12 cycles) then stable high
    bus.SW_RAW = 16'h5A5A;
    repeat (4) @(negedge clk);
    upd_cnt = 0;
    upd_at  = -1;
    for (int c = 0; c < 30; c++) begin
      bus.BTN_ENTER = (c < 12) ? (((c / 2) % 2) == 0) : (c < 24);
      @(negedge clk);
      if (bus.UPDATE) begin
        upd_cnt++;
        upd_at = c + 1;
      end
    end
    chk("bounce_count", 32'(upd_cnt),      32'd1);
    chk("bounce_cycle", 32'(upd_at),       32'd19);
    chk("bounce_sw",    32'(bus.SW),       32'h5A5A);
    chk("bounce_sel",   32'(bus.SELECTOR), 32'(CMP));
    repeat (4) @(negedge clk);

    // reset during the ENTER pulse cycle, with ENTER held through reset
    bus.SW_RAW = 16'h0F0F;
    set_btn(1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 8) set_btn(1'b0, 1'b0, 1'b0);
    end
    chk("pre_rst_pend", 32'(bus.PEND_MODE), 32'(SHR));
    upd_cnt = 0;
    bus.BTN_ENTER = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_upd", 32'(bus.UPDATE), 32'h0);
    rst = 1'b1;
    #1;
    chk("async_sel",  32'(bus.SELECTOR),  32'(ADD));
    chk("async_sw",   32'(bus.SW),        32'h0);
    chk("async_pend", 32'(bus.PEND_MODE), 32'(ADD));
    chk("async_upd",  32'(bus.UPDATE),    32'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (bus.UPDATE) upd_cnt++;
    end
    rst = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.UPDATE) upd_cnt++;
      if (c == 20) bus.BTN_ENTER = 1'b0;
    end
    chk("held_no_update", 32'(upd_cnt),      32'd0);
    chk("held_sel",       32'(bus.SELECTOR), 32'(ADD));
    chk("held_sw",        32'(bus.SW),       32'h0);

    // fresh press after release commits normally
    upd_cnt = 0;
    bus.BTN_ENTER = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (bus.UPDATE) upd_cnt++;
      if (c == 8) bus.BTN_ENTER = 1'b0;
    end
    chk("repress_count", 32'(upd_cnt),      32'd1);
    chk("repress_sw",    32'(bus.SW),       32'h0F0F);
    chk("repress_sel",   32'(bus.SELECTOR), 32'(ADD));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
